fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
Front-end redirect scheduler between the back-end redirect sources and the program counter. It arbitrates branch-mispredict and store-set-violation redirects by ROB age, issues a single registered redirect to the PC stage, and sequences front-end flush and recovery. While a recovery is in flight it holds fetch, and it re-issues a redirect if an older violation arrives mid-recovery.

Parameters:
ROB_DEPTH, 32, number of ROB entries; power of two; sets index width.
FLUSH_CYCLES, 2, number of cycles flush_frontend stays high after a redirect issues; must be 1 to 7.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rob_head_idx  in  log2(ROB_DEPTH)  index of the oldest ROB entry; base for age compare
br_miss  in  1  branch mispredict resolved this cycle
br_target  in  32  correct target PC for br_miss
br_rob_idx  in  log2(ROB_DEPTH)  ROB index of the mispredicted branch
ss_viol  in  1  store-set violation detected this cycle
ss_pc  in  32  re-fetch PC of the violating load
ss_rob_idx  in  log2(ROB_DEPTH)  ROB index of the violating load
recovery_done  in  1  rename/ROB rollback complete
redirect_valid  out  1  one-cycle pulse; PC stage loads redirect_pc
redirect_pc  out  32  redirect target
redirect_is_ss  out  1  current redirect source is the store-set violation
branch_miss_first  out  1  both sources fired and the branch is older
flush_frontend  out  1  squash IF/ID contents
fetch_hold  out  1  stall PC/IF
busy  out  1  FSM not IDLE

Behaviour:
- Reset: FSM=IDLE, pending slot empty, flush counter 0. All outputs 0; redirect_pc=0.
- Age: age(x) = (x - rob_head_idx) mod ROB_DEPTH. Smaller age is older. A tie (same index) selects the store-set source.
- Candidate selection is combinational each cycle. The candidate is the older of the valid requests. branch_miss_first is asserted in the cycle after both fired with the branch strictly older, aligned with redirect_valid.
- IDLE: a candidate in cycle T gives redirect_valid=1 at T+1 with redirect_pc, redirect_is_ss, and the latched rob_idx as active_idx. flush_frontend and fetch_hold are also 1 at T+1, and the counter loads FLUSH_CYCLES-1. Next state is FLUSH.
- FLUSH: flush_frontend=1 and fetch_hold=1. The counter decrements each cycle; at 0 the FSM goes to RECOVER. Total flush_frontend high time is exactly FLUSH_CYCLES cycles.
- RECOVER: flush_frontend=0 and fetch_hold=1. When recovery_done=1 the next state is IDLE, and fetch_hold drops in the following cycle.
- New request while not IDLE:
  - Age strictly older than active_idx: latch it into the pending slot. If the slot is already occupied, the older of the two wins.
  - Age same or younger: drop it, because it is already squashed.
- Pending exit: on recovery_done with the pending slot occupied, the next state is IDLE. Redirect issues from pending in the IDLE cycle (same timing as a fresh request at T = that cycle), and the pending slot clears.
- A fresh request arriving in that same IDLE cycle competes by age with pending. The loser is dropped if younger than the winner.
- recovery_done outside RECOVER is ignored.
- rob_head_idx is sampled live. The ROB head only advances past committed entries, so ages stay consistent across wrap.
- Reset mid-FLUSH or mid-RECOVER: next cycle state is IDLE, pending is cleared, and all outputs are 0.
- Width: age subtraction is log2(ROB_DEPTH) bits with natural wrap. No PC arithmetic is done in this block.

Decomposition:
- Falco_pkg gets pc_t (already present), rob_idx_t, ROB_DEPTH default, and enum redirect_state_t {RD_IDLE, RD_FLUSH, RD_RECOVER}.
- Sub-module rob_age_compare (inputs head, idx_a, idx_b; output a_older) is instantiated twice: once for source arbitration, once for the pending/active check.

Test Plan:
- Single branch miss: head=0, br_miss at T, br_target=0x100, br_rob_idx=5 -> redirect_valid at T+1 with pc 0x100, is_ss=0. flush_frontend high T+1..T+2; fetch_hold high until the cycle after recovery_done.
- Simultaneous, branch older: head=30, br_rob_idx=31, ss_rob_idx=2 -> redirect_pc=br_target, branch_miss_first=1. Checks the wrap case.
- Simultaneous, load older / tie: head=0, br_idx=7, ss_idx=3 -> ss_pc selected, branch_miss_first=0. With equal idx -> ss_pc selected.
- Older violation mid-recovery: active idx 10, ss_viol idx 4 during RECOVER, head=0 -> second redirect to ss_pc in the cycle after recovery_done. A younger idx 12 is dropped and no second redirect issues.
- FLUSH_CYCLES=1 and FLUSH_CYCLES=7 -> flush_frontend width is exactly 1 and 7 cycles.
- rst asserted during RECOVER with pending full -> next cycle all outputs 0 and busy=0. No redirect follows a later recovery_done.

Source files
------------

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the front-end redirect scheduler.
package fetch_redirect_ctrl_pkg;
  localparam int ROB_DEPTH_DEF = 32;

  typedef logic [31:0]                        pc_t;
  typedef logic [$clog2(ROB_DEPTH_DEF)-1:0]   rob_idx_t;
  typedef logic [1:0]                         redirect_state_t;

  localparam redirect_state_t RD_IDLE    = 2'd0;
  localparam redirect_state_t RD_FLUSH   = 2'd1;
  localparam redirect_state_t RD_RECOVER = 2'd2;
endpackage

// File: rtl/fetch_redirect_ctrl_age_cmp.sv
// ROB age comparator: a_older when idx_a is strictly older than idx_b relative to head.
module rob_age_compare #(
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] head,
  input  logic [IDX_W-1:0] idx_a,
  input  logic [IDX_W-1:0] idx_b,
  output logic             a_older
);
  logic [IDX_W-1:0] age_a, age_b;

  always_comb begin
    age_a   = idx_a - head;
    age_b   = idx_b - head;
    a_older = age_a < age_b;
  end
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Arbitrates back-end redirects by ROB age, issues one registered redirect, and sequences flush/recovery.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int ROB_DEPTH    = ROB_DEPTH_DEF,
  parameter int FLUSH_CYCLES = 2,
  localparam int IDX_W       = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rob_head_idx,
  input  logic             br_miss,
  input  logic [31:0]      br_target,
  input  logic [IDX_W-1:0] br_rob_idx,
  input  logic             ss_viol,
  input  logic [31:0]      ss_pc,
  input  logic [IDX_W-1:0] ss_rob_idx,
  input  logic             recovery_done,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             redirect_is_ss,
  output logic             branch_miss_first,
  output logic             flush_frontend,
  output logic             fetch_hold,
  output logic             busy
);
  typedef struct packed {
    pc_t              pc;
    logic [IDX_W-1:0] idx;
    logic             is_ss;
    logic             bmf;
  } req_t;

  redirect_state_t  state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] active_idx_q, active_idx_d;
  logic             pend_vld_q, pend_vld_d;
  req_t             pend_q, pend_d;
  logic             redirect_valid_q, redirect_valid_d;
  pc_t              redirect_pc_q, redirect_pc_d;
  logic             redirect_is_ss_q, redirect_is_ss_d;
  logic             branch_miss_first_q, branch_miss_first_d;

  logic             br_older, cand_older, cand_vld, use_br;
  logic [IDX_W-1:0] ref_idx;
  req_t             cand, sel;

  rob_age_compare #(.IDX_W(IDX_W)) u_src_cmp (
    .head(rob_head_idx), .idx_a(br_rob_idx), .idx_b(ss_rob_idx), .a_older(br_older)
  );

  // Pending (if any) is always older than active, so it is the bar a new request must beat.
  rob_age_compare #(.IDX_W(IDX_W)) u_pend_cmp (
    .head(rob_head_idx), .idx_a(cand.idx), .idx_b(ref_idx), .a_older(cand_older)
  );

  always_comb begin
    cand_vld   = br_miss | ss_viol;
    use_br     = br_miss && (!ss_viol || br_older);
    cand.pc    = use_br ? br_target : ss_pc;
    cand.idx   = use_br ? br_rob_idx : ss_rob_idx;
    cand.is_ss = !use_br;
    cand.bmf   = br_miss && ss_viol && br_older;
    ref_idx    = pend_vld_q ? pend_q.idx : active_idx_q;
  end

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    active_idx_d        = active_idx_q;
    pend_vld_d          = pend_vld_q;
    pend_d              = pend_q;
    redirect_valid_d    = 1'b0;
    redirect_pc_d       = redirect_pc_q;
    redirect_is_ss_d    = redirect_is_ss_q;
    branch_miss_first_d = 1'b0;
    sel                 = pend_q;

    if (state_q != RD_IDLE && cand_vld && cand_older) begin
      pend_vld_d = 1'b1;
      pend_d     = cand;
    end

    case (state_q)
      RD_IDLE: begin
        if (cand_vld || pend_vld_q) begin
          sel                 = (cand_vld && (!pend_vld_q || cand_older)) ? cand : pend_q;
          redirect_valid_d    = 1'b1;
          redirect_pc_d       = sel.pc;
          redirect_is_ss_d    = sel.is_ss;
          branch_miss_first_d = sel.bmf;
          active_idx_d        = sel.idx;
          cnt_d               = 3'(FLUSH_CYCLES - 1);
          pend_vld_d          = 1'b0;
          state_d             = RD_FLUSH;
        end
      end
      RD_FLUSH: begin
        if (cnt_q == 3'd0) state_d = RD_RECOVER;
        else               cnt_d   = cnt_q - 3'd1;
      end
      RD_RECOVER: begin
        if (recovery_done) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= RD_IDLE;
      cnt_q               <= '0;
      active_idx_q        <= '0;
      pend_vld_q          <= 1'b0;
      pend_q              <= '0;
      redirect_valid_q    <= 1'b0;
      redirect_pc_q       <= '0;
      redirect_is_ss_q    <= 1'b0;
      branch_miss_first_q <= 1'b0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      active_idx_q        <= active_idx_d;
      pend_vld_q          <= pend_vld_d;
      pend_q              <= pend_d;
      redirect_valid_q    <= redirect_valid_d;
      redirect_pc_q       <= redirect_pc_d;
      redirect_is_ss_q    <= redirect_is_ss_d;
      branch_miss_first_q <= branch_miss_first_d;
    end
  end

  assign redirect_valid    = redirect_valid_q;
  assign redirect_pc       = redirect_pc_q;
  assign redirect_is_ss    = redirect_is_ss_q;
  assign branch_miss_first = branch_miss_first_q;
  assign flush_frontend    = (state_q == RD_FLUSH);
  assign fetch_hold        = (state_q != RD_IDLE);
  assign busy              = (state_q != RD_IDLE);
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: three instances (FLUSH_CYCLES 2/1/7) share stimulus.
module tb_fetch_redirect_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  head, bi, si;
  logic        br, ss, rd;
  logic [31:0] bt, sp;

  logic        rv[3], ris[3], bmf[3], ff[3], fh[3], bz[3];
  logic [31:0] rpc[3];

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.ROB_DEPTH(32), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .rob_head_idx(head), .br_miss(br), .br_target(bt), .br_rob_idx(bi),
    .ss_viol(ss), .ss_pc(sp), .ss_rob_idx(si), .recovery_done(rd),
    .redirect_valid(rv[0]), .redirect_pc(rpc[0]), .redirect_is_ss(ris[0]),
    .branch_miss_first(bmf[0]), .flush_frontend(ff[0]), .fetch_hold(fh[0]), .busy(bz[0]));

  fetch_redirect_ctrl #(.ROB_DEPTH(32), .FLUSH_CYCLES(1)) dut_f1 (
    .clk(clk), .rst(rst), .rob_head_idx(head), .br_miss(br), .br_target(bt), .br_rob_idx(bi),
    .ss_viol(ss), .ss_pc(sp), .ss_rob_idx(si), .recovery_done(rd),
    .redirect_valid(rv[1]), .redirect_pc(rpc[1]), .redirect_is_ss(ris[1]),
    .branch_miss_first(bmf[1]), .flush_frontend(ff[1]), .fetch_hold(fh[1]), .busy(bz[1]));

  fetch_redirect_ctrl #(.ROB_DEPTH(32), .FLUSH_CYCLES(7)) dut_f7 (
    .clk(clk), .rst(rst), .rob_head_idx(head), .br_miss(br), .br_target(bt), .br_rob_idx(bi),
    .ss_viol(ss), .ss_pc(sp), .ss_rob_idx(si), .recovery_done(rd),
    .redirect_valid(rv[2]), .redirect_pc(rpc[2]), .redirect_is_ss(ris[2]),
    .branch_miss_first(bmf[2]), .flush_frontend(ff[2]), .fetch_hold(fh[2]), .busy(bz[2]));

  typedef struct {
    logic [4:0]  head;
    logic        br;
    logic [31:0] bt;
    logic [4:0]  bi;
    logic        ss;
    logic [31:0] sp;
    logic [4:0]  si;
    logic [31:0] e_pc;
    logic        e_ss;
    logic        e_bmf;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        is_ss;
    logic        bmf;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   rv_cnt = 0;
  int   w_cnt[3]  = '{0, 0, 0};
  int   w_last[3] = '{0, 0, 0};
  int   fc_exp[3] = '{2, 1, 7};

  // Flush pulse widths per instance and a running count of redirects.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ff[k]) w_cnt[k]++;
      else if (w_cnt[k] != 0) begin
        w_last[k] = w_cnt[k];
        w_cnt[k]  = 0;
      end
    end
    if (rv[0]) rv_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic b, input logic [31:0] t, input logic [4:0] bix,
                           input logic s, input logic [31:0] p, input logic [4:0] six);
    @(posedge clk); #1;
    br = b; bt = t; bi = bix; ss = s; sp = p; si = six;
    @(posedge clk); #1;
    br = 1'b0; ss = 1'b0;
  endtask

  task automatic wait_redirect(input string name);
    bit   got = 0;
    exp_t e;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (rv[0]) begin
        got = 1;
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL %s: unexpected redirect pc %0h", name, rpc[0]);
        end else begin
          e = sbq.pop_front();
          check({name, ".pc"},    rpc[0], e.pc);
          check({name, ".is_ss"}, ris[0], e.is_ss);
          check({name, ".bmf"},   bmf[0], e.bmf);
          check({name, ".f1_pc"}, rpc[1], e.pc);
          check({name, ".f7_pc"}, rpc[2], e.pc);
          check({name, ".ff"},    ff[0],  1);
        end
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s: no redirect within 20 cycles", name);
    end
  endtask

  task automatic finish_recovery(input string name);
    repeat (10) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s.width%0d", name, fc_exp[k]), w_last[k], fc_exp[k]);
      check($sformatf("%s.hold_rec%0d", name, k), {fh[k], ff[k]}, 2'b10);
    end
    @(posedge clk); #1 rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("%s.hold_drop%0d", name, k), {fh[k], bz[k]}, 2'b00);
  endtask

  vec_t vecs[8];
  int   snap;

  initial begin
    vecs[0] = '{5'd0,  1'b1, 32'h100, 5'd5,  1'b0, 32'h0,   5'd0,  32'h100, 1'b0, 1'b0};
    vecs[1] = '{5'd30, 1'b1, 32'h200, 5'd31, 1'b1, 32'h300, 5'd2,  32'h200, 1'b0, 1'b1};
    vecs[2] = '{5'd0,  1'b1, 32'h400, 5'd7,  1'b1, 32'h500, 5'd3,  32'h500, 1'b1, 1'b0};
    vecs[3] = '{5'd0,  1'b1, 32'h600, 5'd9,  1'b1, 32'h680, 5'd9,  32'h680, 1'b1, 1'b0};
    vecs[4] = '{5'd20, 1'b0, 32'h0,   5'd0,  1'b1, 32'h700, 5'd19, 32'h700, 1'b1, 1'b0};
    vecs[5] = '{5'd16, 1'b1, 32'h800, 5'd3,  1'b1, 32'h880, 5'd17, 32'h880, 1'b1, 1'b0};
    vecs[6] = '{5'd5,  1'b1, 32'h900, 5'd6,  1'b1, 32'h980, 5'd4,  32'h900, 1'b0, 1'b1};
    vecs[7] = '{5'd5,  1'b1, 32'hA00, 5'd4,  1'b1, 32'hA80, 5'd6,  32'hA80, 1'b1, 1'b0};

    rst = 1'b1; head = '0; br = 0; bt = '0; bi = '0; ss = 0; sp = '0; si = '0; rd = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("reset.outs%0d", k), {rv[k], ris[k], bmf[k], ff[k], fh[k], bz[k]}, 6'b0);
    check("reset.pc", rpc[0], 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      head = vecs[i].head;
      sbq.push_back('{vecs[i].e_pc, vecs[i].e_ss, vecs[i].e_bmf});
      drive_req(vecs[i].br, vecs[i].bt, vecs[i].bi, vecs[i].ss, vecs[i].sp, vecs[i].si);
      wait_redirect($sformatf("vec%0d", i));
      finish_recovery($sformatf("vec%0d", i));
    end

    // Older store-set violation arrives during recovery: re-issued after recovery_done.
    head = 5'd0;
    sbq.push_back('{32'h1000, 1'b0, 1'b0});
    drive_req(1'b1, 32'h1000, 5'd10, 1'b0, 32'h0, 5'd0);
    wait_redirect("pend.first");
    repeat (10) @(posedge clk);
    sbq.push_back('{32'h2000, 1'b1, 1'b0});
    drive_req(1'b0, 32'h0, 5'd0, 1'b1, 32'h2000, 5'd4);
    snap = rv_cnt;
    repeat (3) @(negedge clk);
    check("pend.held", rv_cnt, snap);
    finish_recovery("pend.first");
    wait_redirect("pend.second");
    finish_recovery("pend.second");

    // Younger violation during recovery is dropped.
    sbq.push_back('{32'h3000, 1'b0, 1'b0});
    drive_req(1'b1, 32'h3000, 5'd10, 1'b0, 32'h0, 5'd0);
    wait_redirect("young.first");
    repeat (10) @(posedge clk);
    drive_req(1'b0, 32'h0, 5'd0, 1'b1, 32'h4000, 5'd12);
    snap = rv_cnt;
    finish_recovery("young");
    repeat (6) @(negedge clk);
    check("young.no_redirect", rv_cnt, snap);
    check("young.idle", bz[0], 0);

    // Reset during RECOVER with the pending slot full.
    sbq.push_back('{32'h5000, 1'b0, 1'b0});
    drive_req(1'b1, 32'h5000, 5'd10, 1'b0, 32'h0, 5'd0);
    wait_redirect("rst.first");
    repeat (10) @(posedge clk);
    drive_req(1'b0, 32'h0, 5'd0, 1'b1, 32'h6000, 5'd4);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("rst.outs%0d", k), {rv[k], ris[k], bmf[k], ff[k], fh[k], bz[k]}, 6'b0);
    check("rst.pc", rpc[0], 32'h0);
    snap = rv_cnt;
    @(posedge clk); #1 rd = 1'b1;
    @(posedge clk); #1 rd = 1'b0;
    repeat (6) @(negedge clk);
    check("rst.no_redirect", rv_cnt, snap);
    check("rst.idle", {fh[0], bz[0]}, 2'b00);
    check("sb.empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
